// File: rtl/laconic_pe_pipe.sv
// Pipelined Laconic term-product PE: decode -> histogram -> shift-add reduce -> saturating accumulate.
// Results are returned per dot product over a valid/ready handshake.
module laconic_pe_pipe #(
  parameter int N_LANES = 16,
  parameter int EXP_W   = 3,
  parameter int ACC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic                       approx_en,
  input  logic [N_LANES-1:0]         in_applied,
  input  logic [N_LANES*EXP_W-1:0]   t0,
  input  logic [N_LANES*EXP_W-1:0]   t1,
  input  logic [N_LANES-1:0]         s0,
  input  logic [N_LANES-1:0]         s1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_ovf
);

  localparam int EW = EXP_W + 1;
  localparam int NB = (1 << EW) - 1;
  localparam int CW = $clog2(N_LANES) + 2;
  localparam int NG = (N_LANES + 1) / 2;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_n;

  logic accept;

  // Stage 1: one-hot exponent planes per sign
  logic [NB-1:0][N_LANES-1:0] pos_d, neg_d;
  logic [NB-1:0][N_LANES-1:0] s1_pos, s1_neg;
  logic                       s1_valid, s1_last, s1_approx;

  // Stage 2: signed per-bin counts
  logic [NB-1:0][CW-1:0]      cnt_d;
  logic [NB-1:0][CW-1:0]      s2_cnt;
  logic                       s2_valid, s2_last;

  // Stage 3: aligned batch sum
  logic [ACC_W-1:0]           bsum_d;
  logic [ACC_W-1:0]           s3_sum;
  logic                       s3_valid, s3_last;

  logic [ACC_W-1:0]           acc;
  logic                       ovf;
  logic [ACC_W:0]             sum_w;
  logic                       sat_now;
  logic [ACC_W-1:0]           acc_next;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    logic [EW-1:0] e;
    pos_d = '0;
    neg_d = '0;
    e     = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      e = {1'b0, t0[EXP_W*i +: EXP_W]} + {1'b0, t1[EXP_W*i +: EXP_W]};
      if (in_applied[i]) begin
        if (s0[i] ^ s1[i]) neg_d[e][i] = 1'b1;
        else               pos_d[e][i] = 1'b1;
      end
    end
  end

  // Planes are zero-padded to an even lane count so an odd last lane forms its own group.
  always_comb begin
    logic [2*NG-1:0] pp, nn;
    logic [CW-1:0]   pc_p, pc_n;
    cnt_d = '0;
    pp    = '0;
    nn    = '0;
    pc_p  = '0;
    pc_n  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      pp   = (2*NG)'(s1_pos[b]);
      nn   = (2*NG)'(s1_neg[b]);
      pc_p = '0;
      pc_n = '0;
      if (s1_approx) begin
        for (int unsigned k = 0; k < NG; k++) begin
          pc_p = pc_p + CW'(pp[2*k] | pp[2*k+1]);
          pc_n = pc_n + CW'(nn[2*k] | nn[2*k+1]);
        end
      end else begin
        for (int unsigned k = 0; k < 2*NG; k++) begin
          pc_p = pc_p + CW'(pp[k]);
          pc_n = pc_n + CW'(nn[k]);
        end
      end
      cnt_d[b] = pc_p - pc_n;
    end
  end

  always_comb begin
    bsum_d = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      bsum_d = bsum_d + ({{(ACC_W-CW){s2_cnt[b][CW-1]}}, s2_cnt[b]} << b);
    end
  end

  always_comb begin
    sum_w   = {acc[ACC_W-1], acc} + {s3_sum[ACC_W-1], s3_sum};
    sat_now = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (!sat_now)          acc_next = sum_w[ACC_W-1:0];
    else if (sum_w[ACC_W]) acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    else                   acc_next = {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_approx <= 1'b0;
      s1_pos    <= '0;
      s1_neg    <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_cnt    <= '0;
      s3_valid  <= 1'b0;
      s3_last   <= 1'b0;
      s3_sum    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      s1_valid  <= accept;
      s1_last   <= accept && in_last;
      s1_approx <= approx_en;
      s1_pos    <= accept ? pos_d : '0;
      s1_neg    <= accept ? neg_d : '0;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_cnt    <= cnt_d;
      s3_valid  <= s2_valid;
      s3_last   <= s2_last;
      s3_sum    <= bsum_d;
      if (s3_valid) begin
        if (s3_last) begin
          out_data <= acc_next;
          out_ovf  <= ovf | sat_now;
          acc      <= '0;
          ovf      <= 1'b0;
        end else begin
          acc <= acc_next;
          ovf <= ovf | sat_now;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM: if (accept && in_last)     state_n = DRAIN;
      DRAIN: if (s3_valid && s3_last)   state_n = HOLD;
      HOLD:  if (out_ready)             state_n = ACCUM;
      default:                          state_n = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_laconic_pe_pipe.sv
// Self-checking bench for laconic_pe_pipe: directed vector table, hand sequences and
// randomized dot products checked against a lane-level arithmetic model.
module tb_laconic_pe_pipe;

  localparam int N  = 16;
  localparam int EW = 3;
  localparam int AW = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last, approx_en;
  logic [N-1:0]      in_applied, s0, s1;
  logic [N*EW-1:0]   t0, t1;
  logic              out_valid, out_ready, out_ovf;
  logic [AW-1:0]     out_data;

  int checks = 0;
  int errors = 0;

  longint m_acc;
  logic   m_ovf;

  always #5 clk = ~clk;

  laconic_pe_pipe #(.N_LANES(N), .EXP_W(EW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .approx_en(approx_en),
    .in_applied(in_applied), .t0(t0), .t1(t1), .s0(s0), .s1(s1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  typedef struct {
    string          name;
    logic [N-1:0]   applied;
    logic [N*EW-1:0] a;
    logic [N*EW-1:0] b;
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic           approx;
    longint         exp_data;
    logic           exp_ovf;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Term value of one lane: +/- 2^(t0+t1), or nothing if not applied.
  function automatic longint lane_term(input logic [N-1:0] ap, input logic [N*EW-1:0] a,
                                       input logic [N*EW-1:0] b, input logic [N-1:0] sa,
                                       input logic [N-1:0] sb, input int i);
    longint mag;
    if (!ap[i]) return 0;
    mag = longint'(1) << (int'(a[EW*i +: EW]) + int'(b[EW*i +: EW]));
    return (sa[i] ^ sb[i]) ? -mag : mag;
  endfunction

  function automatic longint model_sum(input logic [N-1:0] ap, input logic [N*EW-1:0] a,
                                       input logic [N*EW-1:0] b, input logic [N-1:0] sa,
                                       input logic [N-1:0] sb, input logic approx);
    longint s = 0;
    longint x, y;
    for (int i = 0; i < N; i += 2) begin
      x = lane_term(ap, a, b, sa, sb, i);
      y = (i + 1 < N) ? lane_term(ap, a, b, sa, sb, i + 1) : 0;
      // In approximate mode two identical signed terms inside a pair collapse to one.
      if (approx && x != 0 && x == y) s += x;
      else                            s += x + y;
    end
    return s;
  endfunction

  task automatic model_acc(input longint bs);
    longint mx = (longint'(1) << (AW - 1)) - 1;
    longint mn = -(longint'(1) << (AW - 1));
    m_acc = m_acc + bs;
    if (m_acc > mx) begin m_acc = mx; m_ovf = 1'b1; end
    if (m_acc < mn) begin m_acc = mn; m_ovf = 1'b1; end
  endtask

  task automatic send(input logic [N-1:0] ap, input logic [N*EW-1:0] a, input logic [N*EW-1:0] b,
                      input logic [N-1:0] sa, input logic [N-1:0] sb, input logic ax,
                      input logic last, input string name);
    bit done = 0;
    in_applied = ap; t0 = a; t1 = b; s0 = sa; s1 = sb; approx_en = ax; in_last = last;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (in_ready) done = 1;
      step;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic get_result(input string name, input longint exp_d, input logic exp_o,
                            input int hold);
    bit     seen = 0;
    longint d0;
    logic   o0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (out_valid) seen = 1;
      else step;
    end
    if (!seen) begin
      chk({name, "_out_timeout"}, 0, 1);
      return;
    end
    chk({name, "_data"}, longint'($signed(out_data)), exp_d);
    chk({name, "_ovf"}, longint'(out_ovf), longint'(exp_o));
    d0 = longint'($signed(out_data));
    o0 = out_ovf;
    for (int h = 0; h < hold; h++) begin
      step;
      chk({name, "_hold_valid"}, longint'(out_valid), 1);
      chk({name, "_hold_data"}, longint'($signed(out_data)), d0);
      chk({name, "_hold_ovf"}, longint'(out_ovf), longint'(o0));
      chk({name, "_hold_in_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk({name, "_ready_after"}, longint'(in_ready), 1);
    chk({name, "_valid_drop"}, longint'(out_valid), 0);
  endtask

  vec_t vt[6];

  initial begin
    logic [N-1:0]    ap, sa, sb;
    logic [N*EW-1:0] a, b;
    logic            ax;
    int              nb;

    vt[0] = '{"exact_basic",  16'h0007, 48'h1D2, 48'h1DB, 16'h0004, 16'h0, 1'b0, -16320, 1'b0};
    vt[1] = '{"approx_basic", 16'h0007, 48'h1D2, 48'h1DB, 16'h0004, 16'h0, 1'b1, -16352, 1'b0};
    vt[2] = '{"neg_e4",       16'h0008, 48'h400, 48'h400, 16'h0008, 16'h0, 1'b0, -16,    1'b0};
    vt[3] = '{"all_zero",     16'h0000, {48{1'b1}}, {48{1'b1}}, 16'hFFFF, 16'h0, 1'b0, 0, 1'b0};
    vt[4] = '{"approx_same_e", 16'h0003, 48'h011, 48'h00A, 16'h0, 16'h0, 1'b1, 8,  1'b0};
    vt[5] = '{"exact_same_e",  16'h0003, 48'h011, 48'h00A, 16'h0, 16'h0, 1'b0, 16, 1'b0};

    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; approx_en = 1'b0; out_ready = 1'b0;
    in_applied = 16'hFFFF; t0 = '0; t1 = '0; s0 = '0; s1 = '0;
    m_acc = 0; m_ovf = 1'b0;

    // Reset with a last batch offered: nothing may be accepted.
    step; step;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step;
      chk("rst_nothing_accepted", longint'(out_valid), 0);
    end

    // Latency: accepted at edge E, result visible after E+3.
    send(vt[0].applied, vt[0].a, vt[0].b, vt[0].sa, vt[0].sb, vt[0].approx, 1'b1, "lat");
    chk("lat_in_ready_low", longint'(in_ready), 0);
    chk("lat_e0", longint'(out_valid), 0);
    step; chk("lat_e1", longint'(out_valid), 0);
    step; chk("lat_e2", longint'(out_valid), 0);
    step; chk("lat_e3", longint'(out_valid), 1);
    get_result("lat", vt[0].exp_data, vt[0].exp_ovf, 0);

    foreach (vt[i]) begin
      send(vt[i].applied, vt[i].a, vt[i].b, vt[i].sa, vt[i].sb, vt[i].approx, 1'b1, vt[i].name);
      get_result(vt[i].name, vt[i].exp_data, vt[i].exp_ovf, 0);
    end

    // Back-to-back multi-batch dot product, then a fresh one to show the accumulator cleared.
    in_applied = 16'h0001; t0 = '0; t1 = '0; s0 = '0; s1 = '0; approx_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_last = (k == 2);
      chk("b2b_in_ready", longint'(in_ready), 1);
      step;
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("multi3", 3, 1'b0, 5);
    send(16'h0008, 48'h400, 48'h400, 16'h0008, 16'h0, 1'b0, 1'b1, "clear");
    get_result("clear", -16, 1'b0, 0);

    // Saturation and sticky-flag clearing.
    send(16'hFFFF, {48{1'b1}}, {48{1'b1}}, 16'h0, 16'h0, 1'b0, 1'b0, "sat_b0");
    send(16'hFFFF, {48{1'b1}}, {48{1'b1}}, 16'h0, 16'h0, 1'b0, 1'b1, "sat_b1");
    get_result("sat", 524287, 1'b1, 2);
    send(16'h0001, 48'h0, 48'h0, 16'h0, 16'h0, 1'b0, 1'b1, "after_sat");
    get_result("after_sat", 1, 1'b0, 0);

    // Randomized dot products against the lane-level model.
    for (int d = 0; d < 40; d++) begin
      m_acc = 0; m_ovf = 1'b0;
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        ap = N'($urandom); sa = N'($urandom); sb = N'($urandom); ax = 1'($urandom);
        for (int i = 0; i < N; i++) begin
          a[EW*i +: EW] = EW'($urandom_range(0, 7));
          b[EW*i +: EW] = EW'(($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 7));
        end
        model_acc(model_sum(ap, a, b, sa, sb, ax));
        send(ap, a, b, sa, sb, ax, (k == nb - 1), "rand");
      end
      get_result("rand", m_acc, m_ovf, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
